clk_div_ctrl: RTL
=================

Name: clk_div_ctrl

Overview:
- Run-time controller for the programmable clock divider. Owns the divide counter and output toggle.
- Accepts new divide factors over a valid/ready handshake and applies them only at full-period boundaries, so clk_out never glitches.
- Sequences start/stop gracefully and emits a one-cycle tick at every clk_out edge for downstream logic. Sits between the board clock and the LE6 display/timing blocks.

Parameters:
WIDTH, 16, width of divide factor and counter
DEFAULT_DIV, 10, half-period (in clk_in cycles) loaded at reset

Ports:
clk_in  input  1  system clock; all logic on posedge
Reset  input  1  synchronous, active-high reset
en  input  1  run request; level-sensitive
div_valid  input  1  new divide factor offered
div_value  input  WIDTH  requested half-period in clk_in cycles
div_ready  output  1  controller can accept div_value this cycle
clk_out  output  1  divided clock, period 2*cur_div clk_in cycles
tick  output  1  one-cycle pulse coincident with every clk_out toggle
busy  output  1  high when state is not STOP
cur_div  output  WIDTH  half-period currently in effect

Behaviour:
- Reset (sampled high on posedge):
  - state=STOP, counter=0, clk_out=0, tick=0.
  - cur_div=DEFAULT_DIV, pend_div=0.
  - div_ready is forced 0 while Reset is high.
  - Reset mid-operation aborts any pending update; the pending value is discarded.
- div_ready = (state != PEND) && !Reset. This is combinational from registered state.
- Handshake: a transfer occurs on a posedge where div_valid && div_ready. div_value is clamped: 0 becomes 1; all other values are used as-is.
- States:
  - STOP:
    - counter held 0, clk_out held 0, tick=0.
    - A transfer updates cur_div on the same edge.
    - en=1 moves to RUN; the counter starts from 0 on that edge.
  - RUN:
    - counter increments each cycle.
    - Terminal count is counter==cur_div-1. On that edge: counter<=0, clk_out toggles, tick<=1 for one cycle. On all other cycles tick=0.
    - A transfer latches pend_div and moves to PEND; cur_div is unchanged.
    - en=0 sampled at a terminal count where clk_out is 1 (i.e., about to fall) moves to STOP on that edge, with clk_out going to 0.
    - en=0 at other cycles keeps running until that boundary. A stop never truncates a high or low phase.
  - PEND:
    - Counts as RUN using the old cur_div.
    - At the first terminal count with clk_out=1: cur_div<=pend_div, clk_out->0, counter->0.
    - Next state is RUN if en=1, STOP if en=0.
    - Terminal counts with clk_out=0 toggle normally and do not apply the update.
- Latency:
  - First clk_out rise occurs cur_div cycles after the RUN-entry edge.
  - An update takes effect at the next full-period boundary, i.e., at most 2*cur_div cycles after acceptance.
- Simultaneous events:
  - Transfer and en=1 in STOP on the same edge: the new value is used from the first period.
  - Transfer in RUN on a boundary edge: the transfer is deferred to PEND, and the boundary is handled as plain RUN (toggle/stop as normal).
  - If en=0 and the boundary coincide, the transfer is still accepted and takes effect on restart.
- Counter/compare are WIDTH bits. cur_div=1 gives clk_out = clk_in/2, with tick high every cycle.
- busy=1 in RUN and PEND; busy=0 in STOP.

Test Plan:
- Reset, then en=1 at edge E0 with DEFAULT_DIV=10 -> clk_out rises at E10, falls at E20, period 20. tick is high only in the cycles after E10, E20, E30.
- Running at div=10: offer div_value=4 mid-high-phase -> div_ready drops and busy stays 1. clk_out finishes the old high phase (10 cycles) and falls; the next high phase is 4 cycles, period 8. div_ready returns high after the switch.
- Running at div=10: drop en 3 cycles into the low phase -> clk_out completes that low phase and the following 10-cycle high phase, then falls and stays 0. busy goes 0, and no further tick occurs.
- In STOP, transfer div_value=0 -> cur_div=1. en=1 -> clk_out toggles every cycle and tick is continuously high.
- In PEND (div 10 -> 6 pending), assert Reset for 1 cycle -> cur_div=10, clk_out=0, state STOP. The pending 6 is never applied.
- Hold div_valid=1 with 3, then 7, back-to-back while running -> 3 is accepted and 7 stalls (div_ready=0) until 3 is applied. 7 is then accepted and applied at the following boundary.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the programmable clock divider: owns the divide counter
// and output toggle, and swaps in new divide factors only at full-period boundaries.
module clk_div_ctrl #(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 10
) (
   input  logic             clk_in,
   input  logic             Reset,
   input  logic             en,
   input  logic             div_valid,
   input  logic [WIDTH-1:0] div_value,
   output logic             div_ready,
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
   output logic [WIDTH-1:0] cur_div
);

   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_counter;
   logic             r_clkOut;
   logic             r_tick;
   logic [WIDTH-1:0] r_curDiv;
   logic [WIDTH-1:0] r_pendDiv;

   state_t           w_nextState;
   logic [WIDTH-1:0] w_nextCounter;
   logic             w_nextClkOut;
   logic             w_nextTick;
   logic [WIDTH-1:0] w_nextCurDiv;
   logic [WIDTH-1:0] w_nextPendDiv;
   logic             w_xfer;
   logic             w_terminal;
   logic [WIDTH-1:0] w_clampDiv;

   assign div_ready  = (r_state != PEND) && !Reset;
   assign w_xfer     = div_valid && div_ready;
   assign w_clampDiv = (div_value == '0) ? WIDTH'(1) : div_value;
   assign w_terminal = (r_counter == r_curDiv - WIDTH'(1));

   always_ff @(posedge clk_in) begin
      if (Reset) begin
         r_state   <= STOP;
         r_counter <= '0;
         r_clkOut  <= 1'b0;
         r_tick    <= 1'b0;
         r_curDiv  <= WIDTH'(DEFAULT_DIV);
         r_pendDiv <= '0;
      end else begin
         r_state   <= w_nextState;
         r_counter <= w_nextCounter;
         r_clkOut  <= w_nextClkOut;
         r_tick    <= w_nextTick;
         r_curDiv  <= w_nextCurDiv;
         r_pendDiv <= w_nextPendDiv;
      end
   end

   always_comb begin
      w_nextState   = r_state;
      w_nextCounter = r_counter;
      w_nextClkOut  = r_clkOut;
      w_nextTick    = 1'b0;
      w_nextCurDiv  = r_curDiv;
      w_nextPendDiv = r_pendDiv;
      case (r_state)
         STOP: begin
            w_nextCounter = '0;
            w_nextClkOut  = 1'b0;
            if (w_xfer) w_nextCurDiv = w_clampDiv;
            if (en) w_nextState = RUN;
         end
         RUN: begin
            if (w_terminal) begin
               w_nextCounter = '0;
               w_nextClkOut  = ~r_clkOut;
               w_nextTick    = 1'b1;
               // Stopping on a falling boundary: a coincident transfer lands directly in
               // cur_div since clk_out is parked low and the value is used on restart.
               if (r_clkOut && !en) begin
                  w_nextState = STOP;
                  if (w_xfer) w_nextCurDiv = w_clampDiv;
               end else if (w_xfer) begin
                  w_nextPendDiv = w_clampDiv;
                  w_nextState   = PEND;
               end
            end else begin
               w_nextCounter = r_counter + WIDTH'(1);
               if (w_xfer) begin
                  w_nextPendDiv = w_clampDiv;
                  w_nextState   = PEND;
               end
            end
         end
         PEND: begin
            if (w_terminal) begin
               w_nextCounter = '0;
               w_nextTick    = 1'b1;
               if (r_clkOut) begin
                  w_nextClkOut = 1'b0;
                  w_nextCurDiv = r_pendDiv;
                  w_nextState  = en ? RUN : STOP;
               end else begin
                  w_nextClkOut = 1'b1;
               end
            end else begin
               w_nextCounter = r_counter + WIDTH'(1);
            end
         end
         default: begin
            w_nextState = STOP;
         end
      endcase
   end

   assign clk_out = r_clkOut;
   assign tick    = r_tick;
   assign busy    = (r_state != STOP);
   assign cur_div = r_curDiv;

endmodule
